// File: rtl/lock_pkg.sv
// Shared definitions for the digital-lock blocks.
//   KEY_*         key codes produced by the 4x4 keypad decoder
//   ctrl_state_t  state encoding of pin_entry_controller
//   is_digit()    true for the numeric keys 0-9
package lock_pkg;

    localparam logic [3:0] KEY_STAR = 4'hF;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] KEY_A    = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_PROG,
        ST_LOCKOUT
    } ctrl_state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Down-counter shared by all timed states of the lock controller.
//   clk, reset  clock / synchronous active-high reset
//   load_val    value loaded on a load strobe
//   load        reload strobe (wins over counting)
//   en          high while the owner sits in a timed state
//   expired     counter reached 1 while enabled (last cycle of the period)
module lock_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] load_val,
    input  logic         load,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset)                    cnt_q <= '0;
        else if (load)                cnt_q <= load_val;
        else if (en && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
    end

    // Loading N makes the period exactly N cycles: N, N-1, ..., 1 -> expire.
    assign expired = en && (cnt_q == W'(1));

endmodule

// File: rtl/pin_entry_controller.sv
// Digital-lock user flow: PIN entry, compare, unlock hold, PIN reprogramming
// and failed-attempt lockout, driven by one-cycle key events.
//   clk, reset   clock / synchronous active-high reset
//   key_value    key code (0-9, A-D, '#'=E, '*'=F), valid with key_valid
//   key_valid    one-cycle key event
//   lock_open    actuator drive, high in OPEN
//   alarm        high in LOCKOUT
//   prog_mode    high in PROG
//   digit_count  digits held in the entry buffer (saturates at PIN_LEN)
//   err_pulse    one-cycle pulse per rejected attempt
//   pin_changed  one-cycle pulse when a new PIN is stored
module pin_entry_controller
    import lock_pkg::*;
#(
    parameter int                   PIN_LEN     = 4,
    parameter logic [4*PIN_LEN-1:0] DEFAULT_PIN = 16'h1234,
    parameter int                   MAX_TRIES   = 3,
    parameter int                   TIMEOUT_CYC = 5000,
    parameter int                   OPEN_CYC    = 5000,
    parameter int                   LOCKOUT_CYC = 30000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_value,
    input  logic       key_valid,
    output logic       lock_open,
    output logic       alarm,
    output logic       prog_mode,
    output logic [3:0] digit_count,
    output logic       err_pulse,
    output logic       pin_changed
);

    localparam int PW   = 4 * PIN_LEN;
    localparam int TMAX = (TIMEOUT_CYC > OPEN_CYC)
                        ? ((TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC)
                        : ((OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_TRIES + 1);

    localparam logic [3:0]    PL4    = 4'(PIN_LEN);
    localparam logic [FW-1:0] MT     = FW'(MAX_TRIES);
    localparam logic [TW-1:0] T_TO   = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYC);
    localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYC);

    ctrl_state_t   state_q, state_n;
    logic [PW-1:0] buf_q, buf_n, pin_q, pin_n;
    logic [3:0]    cnt_q, cnt_n;
    logic          ovl_q, ovl_n;
    logic [FW-1:0] fail_q, fail_n;
    logic          err_n, chg_n;
    logic          t_load, t_en, t_exp;
    logic [TW-1:0] t_val;
    logic          digit, full;

    assign digit = is_digit(key_value);
    assign full  = (cnt_q == PL4) && !ovl_q;
    assign t_en  = (state_q == ST_ENTRY) || (state_q == ST_PROG) ||
                   (state_q == ST_OPEN)  || (state_q == ST_LOCKOUT);

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_val (t_val),
        .load     (t_load),
        .en       (t_en),
        .expired  (t_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            ovl_q       <= 1'b0;
            fail_q      <= '0;
            pin_q       <= DEFAULT_PIN;
            lock_open   <= 1'b0;
            alarm       <= 1'b0;
            prog_mode   <= 1'b0;
            err_pulse   <= 1'b0;
            pin_changed <= 1'b0;
        end else begin
            state_q     <= state_n;
            buf_q       <= buf_n;
            cnt_q       <= cnt_n;
            ovl_q       <= ovl_n;
            fail_q      <= fail_n;
            pin_q       <= pin_n;
            lock_open   <= (state_n == ST_OPEN);
            alarm       <= (state_n == ST_LOCKOUT);
            prog_mode   <= (state_n == ST_PROG);
            err_pulse   <= err_n;
            pin_changed <= chg_n;
        end
    end

    assign digit_count = cnt_q;

    always_comb begin
        state_n = state_q;
        buf_n   = buf_q;
        cnt_n   = cnt_q;
        ovl_n   = ovl_q;
        fail_n  = fail_q;
        pin_n   = pin_q;
        err_n   = 1'b0;
        chg_n   = 1'b0;
        t_load  = 1'b0;
        t_val   = '0;

        case (state_q)
            ST_IDLE: begin
                if (key_valid && digit) begin
                    buf_n   = PW'(key_value);
                    cnt_n   = 4'd1;
                    ovl_n   = 1'b0;
                    state_n = ST_ENTRY;
                end
            end

            // ENTRY and PROG share digit/STAR/timeout handling; expiry is
            // tested first so a coincident key is dropped.
            ST_ENTRY, ST_PROG: begin
                if (t_exp) begin
                    buf_n   = '0;
                    cnt_n   = '0;
                    ovl_n   = 1'b0;
                    state_n = ST_IDLE;
                end else if (key_valid) begin
                    t_load = 1'b1;
                    if (digit) begin
                        if (cnt_q < PL4) begin
                            buf_n = (buf_q << 4) | PW'(key_value);
                            cnt_n = cnt_q + 4'd1;
                        end else begin
                            ovl_n = 1'b1;
                        end
                    end else if (key_value == KEY_STAR) begin
                        buf_n = '0;
                        cnt_n = '0;
                        ovl_n = 1'b0;
                        if (state_q == ST_PROG) state_n = ST_IDLE;
                    end else if (key_value == KEY_HASH) begin
                        if (state_q == ST_ENTRY) begin
                            state_n = ST_CHECK;
                        end else begin
                            if (full) begin
                                pin_n = buf_q;
                                chg_n = 1'b1;
                            end else begin
                                err_n = 1'b1;
                            end
                            buf_n   = '0;
                            cnt_n   = '0;
                            ovl_n   = 1'b0;
                            state_n = ST_IDLE;
                        end
                    end
                end
            end

            ST_CHECK: begin
                buf_n = '0;
                cnt_n = '0;
                ovl_n = 1'b0;
                if (full && buf_q == pin_q) begin
                    fail_n  = '0;
                    state_n = ST_OPEN;
                end else begin
                    // fail_q < MAX_TRIES here, so the increment cannot wrap
                    err_n   = 1'b1;
                    fail_n  = fail_q + 1'b1;
                    state_n = (fail_n == MT) ? ST_LOCKOUT : ST_IDLE;
                end
            end

            ST_OPEN: begin
                if (t_exp) begin
                    state_n = ST_IDLE;
                end else if (key_valid) begin
                    if (key_value == KEY_HASH) begin
                        state_n = ST_IDLE;
                    end else if (key_value == KEY_A) begin
                        buf_n   = '0;
                        cnt_n   = '0;
                        ovl_n   = 1'b0;
                        state_n = ST_PROG;
                    end
                end
            end

            ST_LOCKOUT: begin
                if (t_exp) begin
                    fail_n  = '0;
                    state_n = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase

        // Every state entry restarts the timer with that state's period.
        if (state_n != state_q) t_load = 1'b1;
        case (state_n)
            ST_ENTRY, ST_PROG: t_val = T_TO;
            ST_OPEN:           t_val = T_OPEN;
            ST_LOCKOUT:        t_val = T_LOCK;
            default:           t_val = '0;
        endcase
    end

endmodule
